mul_long_iter: RTL

//   Parametrised iterative long multiplier for the multicycle ARM datapath:
//   MUL/UMULL/SMULL (and, optionally, UMLAL/SMLAL).

---
 rtl/mul_long_iter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mul_long_iter.sv
// mul_long_iter: iterative radix-2 shift-add long multiplier (MUL/UMULL/SMULL).
// Optional feature macro: MUL_ACCUM_EN adds the acc operand in FIX (UMLAL/SMLAL).
// Sequence: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE, done pulses after FIX.
module mul_long_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic                 acc_en,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 res_n,
    output logic                 res_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 res_n_q, res_n_d;
    logic                 res_z_q, res_z_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   fix_p;

`ifdef MUL_ACCUM_EN
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 acc_en_q, acc_en_d;
`else
    logic                 unused_acc;
    assign unused_acc = ^{acc, acc_en};
`endif

    // Final signed fix-up of the magnitude product, plus optional accumulate.
    always_comb begin
        fix_p = sgn_q ? -prod_q : prod_q;
`ifdef MUL_ACCUM_EN
        if (acc_en_q) begin
            fix_p = fix_p + acc_q;
        end
`endif
    end

    // Next-state and datapath updates for the multiply sequence.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        res_n_d = res_n_q;
        res_z_d = res_z_q;
        done_d  = 1'b0;
`ifdef MUL_ACCUM_EN
        acc_d    = acc_q;
        acc_en_d = acc_en_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // |min| = 2^(W-1) still fits as a W-bit unsigned magnitude
                    mcand_d = (is_signed && a[WIDTH-1]) ? -a : a;
                    mplr_d  = (is_signed && b[WIDTH-1]) ? -b : b;
                    sgn_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    prod_d  = '0;
                    cnt_d   = '0;
`ifdef MUL_ACCUM_EN
                    acc_d    = acc;
                    acc_en_d = acc_en;
`endif
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (mplr_q[0]) begin
                    prod_d = prod_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
                end
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = fix_p;
                res_n_d = fix_p[2*WIDTH-1];
                res_z_d = (fix_p == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
            res_n_q <= 1'b0;
            res_z_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUL_ACCUM_EN
            acc_q    <= '0;
            acc_en_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
            res_n_q <= res_n_d;
            res_z_q <= res_z_d;
            done_q  <= done_d;
`ifdef MUL_ACCUM_EN
            acc_q    <= acc_d;
            acc_en_q <= acc_en_d;
`endif
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign result_lo = res_q[WIDTH-1:0];
    assign result_hi = res_q[2*WIDTH-1:WIDTH];
    assign res_n     = res_n_q;
    assign res_z     = res_z_q;

endmodule
